// File: rtl/hash_pkg.sv
// Shared types and constants for the hashcpu instruction-memory loader.
// The loader state encoding is fixed so the debug state output stays stable across builds.
package hash_pkg;

  typedef enum logic [2:0] {
    LDR_IDLE   = 3'd0,
    LDR_HDR_HI = 3'd1,
    LDR_HDR_LO = 3'd2,
    LDR_DATA   = 3'd3,
    LDR_DONE   = 3'd4
  } ldr_state_e;

  localparam int LDR_HDR_W          = 16;
  localparam int LDR_BYTES_PER_WORD = 4;

endpackage

// File: rtl/hash_byte_packer.sv
// Packs a byte stream into 32-bit words, first byte into [31:23+1].
// wordOut/wordValid update on the edge that takes the last byte of a word; wordOut holds otherwise.
module hash_byte_packer
  import hash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byteEn,
  input  logic [7:0]  byteIn,
  output logic [1:0]  byteCnt,
  output logic [31:0] wordOut,
  output logic        wordValid
);

  logic [23:0] shiftReg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shiftReg  <= '0;
      byteCnt   <= '0;
      wordValid <= 1'b0;
    end else begin
      wordValid <= 1'b0;
      if (byteEn) begin
        shiftReg <= {shiftReg[15:0], byteIn};
        byteCnt  <= byteCnt + 2'd1;
        if (byteCnt == 2'(LDR_BYTES_PER_WORD - 1)) begin
          wordValid <= 1'b1;
        end
      end
    end
  end

  // The assembled word survives a restart so the IM data bus keeps its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      wordOut <= '0;
    end else if (byteEn && byteCnt == 2'(LDR_BYTES_PER_WORD - 1)) begin
      wordOut <= {shiftReg, byteIn};
    end
  end

endmodule

// File: rtl/hash_imem_loader.sv
// Fills hashcpu instruction memory from a byte stream: 16-bit word count, then 4-byte words.
// Valid/ready: a byte is taken on any rising edge where in_valid and in_ready are both high.
module hash_imem_loader
  import hash_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output ldr_state_e        dbgState
);

  localparam logic [LDR_HDR_W:0] DEPTH_W = (LDR_HDR_W + 1)'(2 ** ADDR_W);

  ldr_state_e           state;
  ldr_state_e           nextState;
  logic                 errNext;
  logic [7:0]           countHi;
  logic [LDR_HDR_W-1:0] hdrCount;
  logic                 hdrOverflow;
  logic [ADDR_W-1:0]    wordIdx;
  logic [ADDR_W-1:0]    lastIdx;
  logic                 finishPend;
  logic                 accept;
  logic                 startOk;
  logic                 lastByte;
  logic                 finalWord;
  logic [1:0]           byteCnt;

  assign accept      = in_valid && in_ready;
  assign startOk     = start && (state == LDR_IDLE || state == LDR_DONE);
  assign hdrCount    = {countHi, in_data};
  assign hdrOverflow = {1'b0, hdrCount} > DEPTH_W;
  assign lastByte    = accept && state == LDR_DATA && byteCnt == 2'(LDR_BYTES_PER_WORD - 1);
  assign finalWord   = lastByte && wordIdx == lastIdx;
  assign dbgState    = state;

  hash_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (startOk),
    .byteEn    (accept && state == LDR_DATA),
    .byteIn    (in_data),
    .byteCnt   (byteCnt),
    .wordOut   (im_wdata),
    .wordValid (im_we)
  );

  always_comb begin
    nextState = state;
    errNext   = err;
    case (state)
      LDR_IDLE:   if (start) nextState = LDR_HDR_HI;
      LDR_HDR_HI: if (accept) nextState = LDR_HDR_LO;
      LDR_HDR_LO: begin
        if (accept) begin
          if (hdrCount == '0) begin
            nextState = LDR_DONE;
          end else if (hdrOverflow) begin
            nextState = LDR_DONE;
            errNext   = 1'b1;
          end else begin
            nextState = LDR_DATA;
          end
        end
      end
      // Leave DATA only after the final write cycle, so the CPU is never released early.
      LDR_DATA:   if (finishPend) nextState = LDR_DONE;
      LDR_DONE: begin
        if (start) begin
          nextState = LDR_HDR_HI;
          errNext   = 1'b0;
        end
      end
      default:    nextState = LDR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= LDR_IDLE;
      in_ready   <= 1'b0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      countHi    <= '0;
      wordIdx    <= '0;
      lastIdx    <= '0;
      finishPend <= 1'b0;
      im_addr    <= '0;
    end else begin
      state      <= nextState;
      err        <= errNext;
      done       <= (nextState == LDR_DONE);
      cpu_hold   <= (nextState != LDR_DONE) || errNext;
      finishPend <= finalWord;
      // No more bytes are wanted once the last word is assembled.
      in_ready   <= (nextState == LDR_HDR_HI) || (nextState == LDR_HDR_LO) ||
                    (nextState == LDR_DATA && !finalWord && !finishPend);
      if (accept && state == LDR_HDR_HI) countHi <= in_data;
      if (accept && state == LDR_HDR_LO) lastIdx <= ADDR_W'(hdrCount - 16'd1);
      if (startOk) begin
        wordIdx <= '0;
      end else if (lastByte) begin
        im_addr <= wordIdx;
        wordIdx <= wordIdx + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hash_imem_loader.sv
// Directed bench for hash_imem_loader: table of whole loads plus hand-written restart/reset/boundary sequences.
module tb_hash_imem_loader;
  import hash_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  ldr_state_e        dbgState;

  hash_imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] monExp;

  typedef struct {
    logic [7:0]  b [0:9];
    int          nB;
    logic [31:0] w [0:1];
    int          nW;
    logic        expErr;
  } vec_t;

  vec_t tbl [0:3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard: every IM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      nChecks++;
      if (exp_q.size() == 0) begin
        nErrors++;
        $display("FAIL im_write_unexpected got=%0h want=none", {im_addr, im_wdata});
      end else begin
        monExp = exp_q.pop_front();
        if ({im_addr, im_wdata} !== monExp) begin
          nErrors++;
          $display("FAIL im_write got=%0h want=%0h", {im_addr, im_wdata}, monExp);
        end
      end
    end
  end

  task automatic pulseStart(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_start_done"}, 64'(done), 64'd0);
    check({tag, "_start_err"}, 64'(err), 64'd0);
    check({tag, "_start_hold"}, 64'(cpu_hold), 64'd1);
    check({tag, "_start_state"}, 64'(dbgState), 64'(LDR_HDR_HI));
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("byte_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic finishLoad(input string tag, input logic expErr);
    int n;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_err"}, 64'(err), 64'(expErr));
    check({tag, "_hold"}, 64'(cpu_hold), 64'(expErr));
    check({tag, "_ready_idle"}, 64'(in_ready), 64'd0);
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic runVec(input int k);
    string tag;
    tag = $sformatf("vec%0d", k);
    pulseStart(tag);
    for (int i = 0; i < tbl[k].nW; i++) exp_q.push_back({ADDR_W'(i), tbl[k].w[i]});
    for (int i = 0; i < tbl[k].nB; i++) sendByte(tbl[k].b[i], 0);
    finishLoad(tag, tbl[k].expErr);
  endtask

  initial begin
    tbl[0].b = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    tbl[0].nB = 10; tbl[0].w = '{32'hDEADBEEF, 32'h01234567}; tbl[0].nW = 2; tbl[0].expErr = 1'b0;
    tbl[1].b = '{default: 8'h00};
    tbl[1].nB = 2; tbl[1].w = '{default: 32'h0}; tbl[1].nW = 0; tbl[1].expErr = 1'b0;
    tbl[2].b = '{default: 8'h00}; tbl[2].b[0] = 8'h01; tbl[2].b[1] = 8'h01;
    tbl[2].nB = 2; tbl[2].w = '{default: 32'h0}; tbl[2].nW = 0; tbl[2].expErr = 1'b1;
    tbl[3].b = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3].nB = 6; tbl[3].w = '{32'hCAFEF00D, 32'h0}; tbl[3].nW = 1; tbl[3].expErr = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_hold", 64'(cpu_hold), 64'd1);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we", 64'(im_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_addr", 64'(im_addr), 64'd0);
    check("rst_wdata", 64'(im_wdata), 64'd0);
    check("rst_state", 64'(dbgState), 64'(LDR_IDLE));

    for (int k = 0; k < 4; k++) runVec(k);

    // Write and release timing relative to the last byte
    pulseStart("tim");
    exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
    exp_q.push_back({ADDR_W'(1), 32'h01234567});
    for (int i = 0; i < 10; i++) sendByte(tbl[0].b[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("tim_we_t1", 64'(im_we), 64'd1);
    check("tim_done_t1", 64'(done), 64'd0);
    check("tim_hold_t1", 64'(cpu_hold), 64'd1);
    @(negedge clk);
    check("tim_done_t2", 64'(done), 64'd1);
    check("tim_hold_t2", 64'(cpu_hold), 64'd0);
    check("tim_addr_hold", 64'(im_addr), 64'd1);
    check("tim_wdata_hold", 64'(im_wdata), 64'h01234567);

    // Gapped stream with a start pulse mid-DATA
    pulseStart("gap");
    exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
    exp_q.push_back({ADDR_W'(1), 32'h01234567});
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("gap_start_ignored", 64'(dbgState), 64'(LDR_DATA));
        check("gap_start_ready", 64'(in_ready), 64'd1);
      end
      sendByte(tbl[0].b[i], $urandom_range(0, 3));
    end
    finishLoad("gap", 1'b0);

    // Reset after six bytes, then a fresh single-word load
    pulseStart("mid");
    exp_q.push_back({ADDR_W'(0), 32'hDEADBEEF});
    for (int i = 0; i < 6; i++) sendByte(tbl[0].b[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_we", 64'(im_we), 64'd0);
    check("mid_rst_addr", 64'(im_addr), 64'd0);
    check("mid_rst_wdata", 64'(im_wdata), 64'd0);
    check("mid_rst_hold", 64'(cpu_hold), 64'd1);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_state", 64'(dbgState), 64'(LDR_IDLE));
    runVec(3);

    // Full-depth load: N == 2**ADDR_W
    pulseStart("full");
    sendByte(8'h01, 0);
    sendByte(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = {8'(i), 8'h5A, ~8'(i), 8'hC3};
      exp_q.push_back({ADDR_W'(i), w});
      sendByte(w[31:24], 0);
      sendByte(w[23:16], 0);
      sendByte(w[15:8], 0);
      sendByte(w[7:0], 0);
    end
    finishLoad("full", 1'b0);
    check("full_last_addr", 64'(im_addr), 64'd255);
    repeat (5) @(negedge clk);
    check("full_no_extra", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
